wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_skid_fifo.sv | 69 ++++++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback stage and its FPU skid buffer.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int FLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_src_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [FLEN-1:0]   data;
    } fpwb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order FIFO that holds FPU results deferred by pipeline FP writes.
module wb_skid_fifo
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  fpwb_entry_t pushEntry,
    output fpwb_entry_t head,
    output logic [1:0]  count
);

    buf_state_t  state;
    buf_state_t  stateNext;
    fpwb_entry_t mem [2];
    logic        rdPtr;
    logic        wrPtr;
    logic        doPush;
    logic        doPop;

    // A pop on an empty buffer is ignored; a push into a full one only lands if a pop frees a slot.
    assign doPop  = pop && (state != EMPTY);
    assign doPush = push && ((state != FULL) || doPop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
        end else begin
            state <= stateNext;
            if (doPush) wrPtr <= ~wrPtr;
            if (doPop)  rdPtr <= ~rdPtr;
        end
    end

    // NOTE: entry storage is deliberately not reset; the state register alone says what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end

    // NOTE: next state gets its default first so no path through the case can infer a latch.
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY:   if (doPush) stateNext = ONE;
            ONE: begin
                if (doPush && !doPop)      stateNext = FULL;
                else if (doPop && !doPush) stateNext = EMPTY;
            end
            FULL:    if (doPop && !doPush) stateNext = ONE;
            default: stateNext = EMPTY;
        endcase
    end

    always_comb begin
        count = 2'd0;
        case (state)
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    assign head = mem[rdPtr];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: integer/FP register-file write ports, with late FPU results
// merged onto the FP port behind pipeline writes via a two-entry skid buffer.
module wb_arbiter #(
    parameter int XLEN   = wb_pkg::XLEN,
    parameter int FLEN   = wb_pkg::FLEN,
    parameter int REG_AW = wb_pkg::REG_AW,
    parameter int CNT_W  = wb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              result_src_w,
    input  logic              reg_write_w,
    input  logic              freg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [XLEN-1:0]   alu_result_w,
    input  logic [XLEN-1:0]   read_data_w,
    input  logic              fpu_valid,
    input  logic [REG_AW-1:0] fpu_rd,
    input  logic [FLEN-1:0]   fpu_result,
    output logic              fpu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              frf_we,
    output logic [REG_AW-1:0] frf_waddr,
    output logic [FLEN-1:0]   frf_wdata,
    output logic              fpu_wb_pending,
    output logic [CNT_W-1:0]  conflict_cnt
);

    import wb_pkg::*;

    logic            settle;
    logic            active;
    logic [XLEN-1:0] wbData;
    fpwb_entry_t     pushEntry;
    fpwb_entry_t     fifoHead;
    logic [1:0]      fifoCount;
    logic            fifoEmpty;
    logic            accept;
    logic            enqueue;
    logic            bypass;
    logic            drain;

    // Writes are blocked while reset is asserted and for one settle cycle after it falls.
    assign active = !reset && !settle;

    assign wbData = (result_src_t'(result_src_w) == RES_MEM) ? read_data_w : alu_result_w;

    assign rf_we    = active && reg_write_w && (rd_w != '0);
    assign rf_waddr = rd_w;
    assign rf_wdata = wbData;

    assign fifoEmpty      = (fifoCount == 2'd0);
    assign fpu_ready      = active && (fifoCount != 2'd2);
    assign fpu_wb_pending = !reset && !fifoEmpty;

    assign accept  = fpu_valid && fpu_ready;
    assign enqueue = accept && (!fifoEmpty || freg_write_w);
    assign bypass  = accept && fifoEmpty && !freg_write_w;
    assign drain   = active && !fifoEmpty && !freg_write_w;

    assign pushEntry.rd   = fpu_rd;
    assign pushEntry.data = fpu_result;

    wb_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (enqueue),
        .pop       (drain),
        .pushEntry (pushEntry),
        .head      (fifoHead),
        .count     (fifoCount)
    );

    // Pipeline write first, then the buffered head, then a same-cycle FPU bypass.
    always_comb begin
        frf_we    = 1'b0;
        frf_waddr = '0;
        frf_wdata = '0;
        if (active && freg_write_w) begin
            frf_we    = 1'b1;
            frf_waddr = rd_w;
            frf_wdata = wbData[FLEN-1:0];
        end else if (drain) begin
            frf_we    = 1'b1;
            frf_waddr = fifoHead.rd;
            frf_wdata = fifoHead.data;
        end else if (bypass) begin
            frf_we    = 1'b1;
            frf_waddr = fpu_rd;
            frf_wdata = fpu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle       <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            settle <= 1'b0;
            if (enqueue && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; a second instance with a 2-bit
// counter shares the stimulus to exercise conflict counter saturation.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        result_src_w;
    logic        reg_write_w;
    logic        freg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] alu_result_w;
    logic [31:0] read_data_w;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_result;

    logic        fpu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        frf_we;
    logic [4:0]  frf_waddr;
    logic [31:0] frf_wdata;
    logic        fpu_wb_pending;
    logic [15:0] conflict_cnt;

    logic        sFpuReady;
    logic        sRfWe;
    logic [4:0]  sRfWaddr;
    logic [31:0] sRfWdata;
    logic        sFrfWe;
    logic [4:0]  sFrfWaddr;
    logic [31:0] sFrfWdata;
    logic        sPending;
    logic [1:0]  sCnt;

    int nChecks = 0;
    int nPass   = 0;

    wb_arbiter dut (
        .clk(clk), .reset(reset), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
        .freg_write_w(freg_write_w), .rd_w(rd_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .fpu_valid(fpu_valid), .fpu_rd(fpu_rd),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata),
        .fpu_wb_pending(fpu_wb_pending), .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
        .freg_write_w(freg_write_w), .rd_w(rd_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .fpu_valid(fpu_valid), .fpu_rd(fpu_rd),
        .fpu_result(fpu_result), .fpu_ready(sFpuReady), .rf_we(sRfWe), .rf_waddr(sRfWaddr),
        .rf_wdata(sRfWdata), .frf_we(sFrfWe), .frf_waddr(sFrfWaddr), .frf_wdata(sFrfWdata),
        .fpu_wb_pending(sPending), .conflict_cnt(sCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settleInputs();
        #2;
    endtask

    initial begin
        logic [1:0] satExp;

        reset        = 1'b1;
        result_src_w = 1'b0;
        reg_write_w  = 1'b1;
        freg_write_w = 1'b1;
        rd_w         = 5'd3;
        alu_result_w = 32'h0;
        read_data_w  = 32'h0;
        fpu_valid    = 1'b0;
        fpu_rd       = 5'd0;
        fpu_result   = 32'h0;

        // Reset held over two edges with write requests present.
        tick();
        tick();
        check("reset_rf_we", rf_we, 0);
        check("reset_frf_we", frf_we, 0);
        check("reset_fpu_ready", fpu_ready, 0);
        check("reset_pending", fpu_wb_pending, 0);
        check("reset_cnt", conflict_cnt, 0);
        check("reset_sat_cnt", sCnt, 0);

        // Settle cycle: everything suppressed regardless of inputs.
        reset        = 1'b0;
        freg_write_w = 1'b0;
        fpu_valid    = 1'b1;
        fpu_rd       = 5'd30;
        fpu_result   = 32'h1234_5678;
        settleInputs();
        check("settle_rf_we", rf_we, 0);
        check("settle_frf_we", frf_we, 0);
        check("settle_fpu_ready", fpu_ready, 0);
        tick();

        // Load writeback to x3, then ALU result, then x0 suppression.
        fpu_valid    = 1'b0;
        result_src_w = 1'b1;
        read_data_w  = 32'hDEAD_BEEF;
        alu_result_w = 32'h1111_1111;
        settleInputs();
        check("load_rf_we", rf_we, 1);
        check("load_rf_waddr", rf_waddr, 3);
        check("load_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("load_frf_we", frf_we, 0);
        check("post_settle_ready", fpu_ready, 1);
        result_src_w = 1'b0;
        settleInputs();
        check("alu_rf_wdata", rf_wdata, 32'h1111_1111);
        rd_w = 5'd0;
        settleInputs();
        check("x0_rf_we", rf_we, 0);
        tick();

        // Bypass: FPU result lands in the same cycle with an empty buffer.
        reg_write_w = 1'b0;
        fpu_valid   = 1'b1;
        fpu_rd      = 5'd7;
        fpu_result  = 32'h3F80_0000;
        settleInputs();
        check("bypass_frf_we", frf_we, 1);
        check("bypass_frf_waddr", frf_waddr, 7);
        check("bypass_frf_wdata", frf_wdata, 32'h3F80_0000);
        tick();
        fpu_valid = 1'b0;
        settleInputs();
        check("bypass_cnt", conflict_cnt, 0);
        check("bypass_pending", fpu_wb_pending, 0);
        check("bypass_idle_frf_we", frf_we, 0);

        // Collision: pipeline write to f2 wins, FPU f9 drains next cycle.
        freg_write_w = 1'b1;
        rd_w         = 5'd2;
        alu_result_w = 32'h4000_0000;
        fpu_valid    = 1'b1;
        fpu_rd       = 5'd9;
        fpu_result   = 32'h4110_0000;
        settleInputs();
        check("coll_pipe_waddr", frf_waddr, 2);
        check("coll_pipe_wdata", frf_wdata, 32'h4000_0000);
        check("coll_ready", fpu_ready, 1);
        tick();
        freg_write_w = 1'b0;
        fpu_valid    = 1'b0;
        settleInputs();
        check("coll_drain_we", frf_we, 1);
        check("coll_drain_waddr", frf_waddr, 9);
        check("coll_drain_wdata", frf_wdata, 32'h4110_0000);
        check("coll_pending", fpu_wb_pending, 1);
        check("coll_cnt", conflict_cnt, 1);
        tick();
        settleInputs();
        check("coll_empty_pending", fpu_wb_pending, 0);
        check("coll_empty_frf_we", frf_we, 0);

        // Back-pressure: three FPU results against three pipeline FP writes.
        freg_write_w = 1'b1;
        rd_w         = 5'd1;
        alu_result_w = 32'hA000_0001;
        fpu_valid    = 1'b1;
        fpu_rd       = 5'd10;
        fpu_result   = 32'hC000_000A;
        settleInputs();
        check("bp1_waddr", frf_waddr, 1);
        check("bp1_ready", fpu_ready, 1);
        tick();
        rd_w         = 5'd4;
        alu_result_w = 32'hA000_0004;
        fpu_rd       = 5'd11;
        fpu_result   = 32'hC000_000B;
        settleInputs();
        check("bp2_waddr", frf_waddr, 4);
        check("bp2_ready", fpu_ready, 1);
        tick();
        rd_w         = 5'd5;
        alu_result_w = 32'hA000_0005;
        fpu_rd       = 5'd12;
        fpu_result   = 32'hC000_000C;
        settleInputs();
        check("bp3_waddr", frf_waddr, 5);
        check("bp3_wdata", frf_wdata, 32'hA000_0005);
        check("bp3_ready", fpu_ready, 0);
        check("bp3_cnt", conflict_cnt, 3);
        tick();
        // Burst over: f10 drains while f12 is still held by the FPU.
        freg_write_w = 1'b0;
        settleInputs();
        check("bp_drain1_waddr", frf_waddr, 10);
        check("bp_drain1_wdata", frf_wdata, 32'hC000_000A);
        check("bp_drain1_ready", fpu_ready, 0);
        tick();
        settleInputs();
        check("bp_drain2_waddr", frf_waddr, 11);
        check("bp_drain2_wdata", frf_wdata, 32'hC000_000B);
        check("bp_drain2_ready", fpu_ready, 1);
        tick();
        fpu_valid = 1'b0;
        settleInputs();
        check("bp_drain3_we", frf_we, 1);
        check("bp_drain3_waddr", frf_waddr, 12);
        check("bp_drain3_wdata", frf_wdata, 32'hC000_000C);
        check("bp_cnt", conflict_cnt, 4);
        check("bp_sat_cnt", sCnt, 3);
        tick();
        settleInputs();
        check("bp_done_pending", fpu_wb_pending, 0);

        // Fill the buffer, then reset: buffered results must vanish.
        freg_write_w = 1'b1;
        rd_w         = 5'd6;
        fpu_valid    = 1'b1;
        fpu_rd       = 5'd13;
        fpu_result   = 32'hC000_000D;
        tick();
        rd_w         = 5'd8;
        fpu_rd       = 5'd14;
        fpu_result   = 32'hC000_000E;
        tick();
        freg_write_w = 1'b0;
        fpu_valid    = 1'b0;
        settleInputs();
        check("full_pending", fpu_wb_pending, 1);
        check("full_ready", fpu_ready, 0);
        check("full_cnt", conflict_cnt, 6);
        reset = 1'b1;
        settleInputs();
        check("midrst_frf_we", frf_we, 0);
        tick();
        check("midrst_pending", fpu_wb_pending, 0);
        check("midrst_cnt", conflict_cnt, 0);
        check("midrst_sat_cnt", sCnt, 0);
        reset = 1'b0;
        settleInputs();
        check("midrst_settle_we", frf_we, 0);
        tick();
        settleInputs();
        check("midrst_after_we", frf_we, 0);
        check("midrst_after_pending", fpu_wb_pending, 0);
        tick();
        settleInputs();
        check("midrst_after2_we", frf_we, 0);

        // Five deferred results: the 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) begin
            freg_write_w = 1'b1;
            rd_w         = 5'(20 + i);
            alu_result_w = 32'hB000_0000 + 32'(i);
            fpu_valid    = 1'b1;
            fpu_rd       = 5'(16 + i);
            fpu_result   = 32'hC000_0010 + 32'(i);
            settleInputs();
            check("sat_pipe_waddr", frf_waddr, 32'(20 + i));
            tick();
            freg_write_w = 1'b0;
            fpu_valid    = 1'b0;
            satExp       = (i >= 2) ? 2'd3 : 2'(i + 1);
            settleInputs();
            check("sat_drain_waddr", frf_waddr, 32'(16 + i));
            check("sat_drain_wdata", frf_wdata, 32'hC000_0010 + 32'(i));
            check("sat_cnt_step", sCnt, satExp);
            tick();
        end
        check("sat_final_sat_cnt", sCnt, 3);
        check("sat_final_cnt", conflict_cnt, 5);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
